odd_even_scheduler: RTL and testbench
=====================================

# odd_even_scheduler

Shares one parity counter between two requesters: channel 0 consumes even values, channel 1 consumes odd values. The block owns the 4-bit step-by-2 counter and drives its mode. It grants bursts round-robin and tracks each parity's resume point, so every channel sees a continuous sequence. It sits between the odd/even counter datapath and the consumers that need parity-tagged sequence numbers.

## Interface
- WIDTH, 4, counter width in bits (>=2)
- BURST, 4, max values issued per grant (>=1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[0] even channel, req[1] odd channel; level request / consume enable
- gnt  out  2  one-hot grant, registered
- mode  out  1  parity being generated (0 even, 1 odd), registered
- cnt  out  WIDTH  current counter value, registered
- cnt_valid  out  1  cnt valid for the granted channel, registered
- done  out  1  one-cycle pulse, burst ended, registered

## Operation
- States: IDLE, RUN.
- Reset values: state IDLE, gnt=00, mode=0, cnt=0, cnt_valid=0, done=0, beat=0, last=1 (even wins first arbitration), resume_even=0, resume_odd=1.
- IDLE, on each edge with req!=00:
  - Pick g: the single requester, or !last if both request.
  - gnt<=onehot(g), mode<=g, cnt<=start(g), beat<=0, cnt_valid<=1, last<=g, state<=RUN.
- RUN, on each edge. Consume = cnt_valid & req[g].
  - Consume and beat<BURST-1: cnt<=cnt+2 mod 2^WIDTH, beat++.
  - Consume and beat==BURST-1: save cnt+2 into resume_g and end the burst.
  - No consume (req[g] low): save cnt, which was not consumed, into resume_g and end the burst.
- End burst: state<=IDLE, gnt<=00, cnt_valid<=0, done<=1; mode and cnt hold.
- done is cleared on the next edge unless another burst ends.
- Arithmetic: add 2 modulo 2^WIDTH, which preserves parity. Wraps: even 14->0, odd 15->1 for WIDTH=4.
- Values are never skipped or repeated within a parity, except after reset.

## Timing
- Request-to-first-value latency: 1 cycle. If req seen at edge k (state IDLE), cnt_valid=1 after edge k.
- Throughput: one value per cycle during RUN.
- Minimum gap between bursts: 1 cycle. The done cycle is an IDLE cycle, and arbitration happens on the edge ending it.
- Back-to-back with both requesting: BURST valid cycles, then 1 bubble, then the other channel.
- Starvation bound: one burst plus one bubble.
- A req drop is seen on the same edge. The displayed value stays unconsumed and is reissued at the channel's next grant.
- rst asserted at any time, mid-burst included: all outputs and registers go to reset values immediately, with no clock needed. The first edge after release is treated as IDLE.

## Configuration
- ODD_EVEN_RESUME_EN defined:
  - start(0)=resume_even, start(1)=resume_odd.
  - Each channel continues its sequence across grants.
- Not defined:
  - resume registers are not implemented.
  - start(0)=0, start(1)=1 on every grant; each burst restarts at the parity base.

## Test plan
- WIDTH=4, BURST=4, req=01 held from reset release:
  - gnt=01, cnt 0,2,4,6 with cnt_valid, then done, 1 bubble.
  - Next burst 8,10,12,14 with the macro; 0,2,4,6 without.
- req=11 held:
  - even 0,2,4,6; bubble; odd 1,3,5,7; bubble; even 8,10,12,14.
  - gnt alternates 01/10; mode follows.
- Wrap, macro on, req=10 held for three bursts:
  - odd 1,3,5,7 / 9,11,13,15 / 1,3,5,7.
  - No value ≥16; parity always 1.
- Early drop, macro on:
  - req[1] high for 2 valid cycles (1,3 consumed), low while cnt=5.
  - done on that edge; the next odd grant starts at 5.
- Reset mid-burst:
  - rst pulsed while cnt=4, gnt=01: gnt=00, cnt=0, cnt_valid=0, mode=0 before the next edge.
  - After release with req=11, the even channel is granted first starting at 0.
- BURST=1, req=11: cnt_valid every other cycle; values 0,1,2,3,4… with the macro, alternating gnt.

Source files
------------

// File: rtl/odd_even_scheduler.sv
// Round-robin burst scheduler for a shared step-by-2 parity counter (channel 0 even, channel 1 odd).
// Define ODD_EVEN_RESUME_EN to let each channel continue its sequence across grants.
module odd_even_scheduler #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             mode,
  output logic [WIDTH-1:0] cnt,
  output logic             cnt_valid,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int               BW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST - 1);
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(2);

  state_t           state, state_nx;
  logic [1:0]       gnt_nx;
  logic             mode_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic             cnt_valid_nx;
  logic             done_nx;
  logic [BW-1:0]    beat, beat_nx;
  logic             last, last_nx;
  logic             pick;
  logic             consume;
  logic             end_burst;
  logic [WIDTH-1:0] cnt_plus2;
  logic [WIDTH-1:0] start_val;

`ifdef ODD_EVEN_RESUME_EN
  logic [WIDTH-1:0] resume_even, resume_even_nx;
  logic [WIDTH-1:0] resume_odd, resume_odd_nx;
  logic [WIDTH-1:0] save_val;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    mode_nx      = mode;
    cnt_nx       = cnt;
    cnt_valid_nx = cnt_valid;
    done_nx      = 1'b0;
    beat_nx      = beat;
    last_nx      = last;
    end_burst    = 1'b0;
    consume      = cnt_valid & req[mode];
    cnt_plus2    = cnt + STEP;
    // Both requesting: the channel not served last wins.
    pick         = (req == 2'b11) ? ~last : req[1];
`ifdef ODD_EVEN_RESUME_EN
    start_val      = pick ? resume_odd : resume_even;
    resume_even_nx = resume_even;
    resume_odd_nx  = resume_odd;
    save_val       = consume ? cnt_plus2 : cnt;
`else
    start_val    = {{(WIDTH-1){1'b0}}, pick};
`endif

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_nx       = pick ? 2'b10 : 2'b01;
          mode_nx      = pick;
          cnt_nx       = start_val;
          beat_nx      = '0;
          cnt_valid_nx = 1'b1;
          last_nx      = pick;
          state_nx     = RUN;
        end
      end
      RUN: begin
        if (consume && beat != BEAT_LAST) begin
          cnt_nx  = cnt_plus2;
          beat_nx = beat + BW'(1);
        end else begin
          end_burst = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // mode and cnt hold through the done cycle.
    if (end_burst) begin
      state_nx     = IDLE;
      gnt_nx       = 2'b00;
      cnt_valid_nx = 1'b0;
      done_nx      = 1'b1;
`ifdef ODD_EVEN_RESUME_EN
      if (mode) resume_odd_nx = save_val;
      else      resume_even_nx = save_val;
`endif
    end
  end

  // NOTE: state registers take non-blocking assignments only; the async reset clears every one of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      mode        <= 1'b0;
      cnt         <= '0;
      cnt_valid   <= 1'b0;
      done        <= 1'b0;
      beat        <= '0;
      last        <= 1'b1;
`ifdef ODD_EVEN_RESUME_EN
      resume_even <= '0;
      resume_odd  <= WIDTH'(1);
`endif
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      mode        <= mode_nx;
      cnt         <= cnt_nx;
      cnt_valid   <= cnt_valid_nx;
      done        <= done_nx;
      beat        <= beat_nx;
      last        <= last_nx;
`ifdef ODD_EVEN_RESUME_EN
      resume_even <= resume_even_nx;
      resume_odd  <= resume_odd_nx;
`endif
    end
  end

endmodule

// File: tb/tb_odd_even_scheduler.sv
// Self-checking bench for odd_even_scheduler: burst-level reference model plus directed and random scenarios.
// Honours ODD_EVEN_RESUME_EN the same way the design does.
module tb_odd_even_scheduler;

  localparam int TB_BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] req1 = 2'b00;
  logic [1:0] gnt, gnt1;
  logic       mode, mode1;
  logic [3:0] cnt, cnt1;
  logic       cnt_valid, cnt_valid1;
  logic       done, done1;

  int n_tests = 0;
  int n_fail  = 0;

  odd_even_scheduler #(.WIDTH(4), .BURST(TB_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .mode(mode),
    .cnt(cnt), .cnt_valid(cnt_valid), .done(done)
  );

  odd_even_scheduler #(.WIDTH(4), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .mode(mode1),
    .cnt(cnt1), .cnt_valid(cnt_valid1), .done(done1)
  );

  always #5 clk = ~clk;

  // Reference model: a burst is "which channel, how many values shown"; each channel
  // keeps the next value it should see as a plain integer.
  bit         m_busy;
  int         m_ch;
  int         m_shown;
  int         m_next[2];
  int         m_last;
  logic [1:0] e_gnt;
  logic       e_mode;
  logic [3:0] e_cnt;
  logic       e_valid;
  logic       e_done;

  function automatic void model_reset();
    m_busy = 0; m_ch = 0; m_shown = 0; m_last = 1;
    m_next[0] = 0; m_next[1] = 1;
    e_gnt = 2'b00; e_mode = 1'b0; e_cnt = 4'd0; e_valid = 1'b0; e_done = 1'b0;
  endfunction

  function automatic void finish_burst(int resume_at);
    m_next[m_ch] = resume_at % 16;
    m_busy  = 0;
    e_gnt   = 2'b00;
    e_valid = 1'b0;
    e_done  = 1'b1;
  endfunction

  function automatic void model_step(logic [1:0] r);
    int v;
    e_done = 1'b0;
    if (!m_busy) begin
      if (r != 2'b00) begin
        m_ch = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
        m_last = m_ch;
`ifdef ODD_EVEN_RESUME_EN
        v = m_next[m_ch];
`else
        v = m_ch;
`endif
        m_busy  = 1;
        m_shown = 1;
        e_cnt   = 4'(v);
        e_gnt   = (m_ch == 1) ? 2'b10 : 2'b01;
        e_mode  = (m_ch == 1);
        e_valid = 1'b1;
      end
    end else if (r[m_ch]) begin
      v = (int'(e_cnt) + 2) % 16;
      if (m_shown < TB_BURST) begin
        e_cnt = 4'(v);
        m_shown++;
      end else begin
        finish_burst(v);
      end
    end else begin
      finish_burst(int'(e_cnt));
    end
  endfunction

  function automatic logic [8:0] act_vec();
    return {gnt, mode, cnt, cnt_valid, done};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {e_gnt, e_mode, e_cnt, e_valid, e_done};
  endfunction

  function automatic string fmt(logic [8:0] v);
    return $sformatf("gnt=%b mode=%b cnt=%0d valid=%b done=%b", v[8:7], v[6], v[5:2], v[1], v[0]);
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req = 2'b00; req1 = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (act_vec() !== 9'b0 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got %s, expected %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_single_even();
`ifdef ODD_EVEN_RESUME_EN
    int ev[8] = '{0, 2, 4, 6, 8, 10, 12, 14};
`else
    int ev[8] = '{0, 2, 4, 6, 0, 2, 4, 6};
`endif
    int got[$];
    apply_reset();
    req = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_even cycle %0d: got %s, expected %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
      if (cnt_valid) got.push_back(int'(cnt));
    end
    n_tests++;
    if (got.size() < 8) begin
      n_fail++;
      $display("FAIL single_even_count: got %0d values, expected at least 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got[i] != ev[i]) begin
          n_fail++;
          $display("FAIL single_even_value %0d: got %0d, expected %0d", i, got[i], ev[i]);
        end
      end
    end
  endtask

  task automatic test_alternate();
`ifdef ODD_EVEN_RESUME_EN
    int ev[12] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14};
`else
    int ev[12] = '{0, 2, 4, 6, 1, 3, 5, 7, 0, 2, 4, 6};
`endif
    int got[$];
    apply_reset();
    req = 2'b11;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL alternate cycle %0d: got %s, expected %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
      if (cnt_valid) got.push_back(int'(cnt));
    end
    n_tests++;
    if (got.size() != 12) begin
      n_fail++;
      $display("FAIL alternate_count: got %0d values, expected 12", got.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (got[i] != ev[i]) begin
          n_fail++;
          $display("FAIL alternate_value %0d: got %0d, expected %0d", i, got[i], ev[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
`ifdef ODD_EVEN_RESUME_EN
    int ev[12] = '{1, 3, 5, 7, 9, 11, 13, 15, 1, 3, 5, 7};
`else
    int ev[12] = '{1, 3, 5, 7, 1, 3, 5, 7, 1, 3, 5, 7};
`endif
    int got[$];
    apply_reset();
    req = 2'b10;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap cycle %0d: got %s, expected %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
      if (cnt_valid) begin
        got.push_back(int'(cnt));
        n_tests++;
        if (cnt[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_parity cycle %0d: got cnt=%0d, expected an odd value", i, cnt);
        end
      end
    end
    n_tests++;
    if (got.size() != 12) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d values, expected 12", got.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (got[i] != ev[i]) begin
          n_fail++;
          $display("FAIL wrap_value %0d: got %0d, expected %0d", i, got[i], ev[i]);
        end
      end
    end
  endtask

  task automatic test_early_drop();
`ifdef ODD_EVEN_RESUME_EN
    logic [3:0] regrant = 4'd5;
`else
    logic [3:0] regrant = 4'd1;
`endif
    apply_reset();
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL early_drop run %0d: got %s, expected %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
    req = 2'b00;
    tick();
    n_tests++;
    if (done !== 1'b1 || cnt_valid !== 1'b0 || gnt !== 2'b00 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL early_drop_end: got %s, expected %s", fmt(act_vec()), fmt(exp_vec()));
    end
    req = 2'b10;
    tick();
    n_tests++;
    if (cnt !== regrant || gnt !== 2'b10 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL early_drop_regrant: got %s, expected cnt=%0d and %s", fmt(act_vec()), regrant, fmt(exp_vec()));
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 2'b01;
    repeat (3) tick();
    n_tests++;
    if (cnt !== 4'd4 || gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got gnt=%b cnt=%0d, expected gnt=01 cnt=4", gnt, cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (act_vec() !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %s, expected all outputs zero", fmt(act_vec()));
    end
    #1 rst = 1'b0;
    model_reset();
    req = 2'b11;
    tick();
    n_tests++;
    if (gnt !== 2'b01 || cnt !== 4'd0 || cnt_valid !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_reset_first_grant: got %s, expected %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : req;
      tick();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d req=%b: got %s, expected %s", i, req, fmt(act_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_burst1();
    logic [1:0] eg;
    logic [3:0] ec;
    logic       ev;
    apply_reset();
    req1 = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      ev = (i % 2 == 0);
      eg = ev ? (((i / 2) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
`ifdef ODD_EVEN_RESUME_EN
      ec = 4'(i / 2);
`else
      ec = 4'((i / 2) % 2);
`endif
      n_tests++;
      if (cnt_valid1 !== ev || gnt1 !== eg || done1 !== !ev || cnt1 !== ec) begin
        n_fail++;
        $display("FAIL burst1 cycle %0d: got gnt=%b cnt=%0d valid=%b done=%b, expected gnt=%b cnt=%0d valid=%b done=%b",
                 i, gnt1, cnt1, cnt_valid1, done1, eg, ec, ev, !ev);
      end
    end
    req1 = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_even();
    test_alternate();
    test_wrap();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    test_burst1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
